// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift datapath: rotate-code layout,
// unrotate FSM states and the code-to-left-rotate-amount mapping.
package shift_pkg;

  localparam int SHIFT_WIDTH = 16;
  localparam int SHIFT_LOG2N = $clog2(SHIFT_WIDTH);

  typedef struct packed {
    logic                   dir;
    logic [SHIFT_LOG2N-1:0] k;
  } rot_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } unrot_state_t;

  // dir=1 undoes a right gather, so the left amount is (WIDTH-k) mod WIDTH;
  // the subtraction wraps naturally in LOG2N bits, so k=0 gives 0.
  function automatic logic [SHIFT_LOG2N-1:0] rot_left_amt(input rot_code_t code);
    logic [SHIFT_LOG2N-1:0] amt;
    if (code.dir) begin
      amt = SHIFT_LOG2N'(0) - code.k;
    end else begin
      amt = code.k;
    end
    return amt;
  endfunction

endpackage

// File: rtl/rot_stage.sv
// One radix-2 rotate stage: rotates the word left by the constant SHIFT
// when enabled, otherwise passes it through untouched.
module rot_stage #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_rot;

  assign w_rot  = {i_data[WIDTH-SHIFT-1:0], i_data[WIDTH-1:WIDTH-SHIFT]};
  assign o_data = i_en ? w_rot : i_data;

endmodule

// File: rtl/bit_unrotate_seq.sv
// Multi-cycle inverse of the {dir,k} bit-gather network: restores the
// original bit order by applying one power-of-two rotate stage per clock.
module bit_unrotate_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int LOG2N = $clog2(WIDTH),
  localparam int CODEW = LOG2N + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CODEW-1:0] i_code,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(LOG2N - 1);

  unrot_state_t     r_state;
  unrot_state_t     w_state_next;
  logic [LOG2N-1:0] r_cnt;
  logic [LOG2N-1:0] w_cnt_next;
  logic [LOG2N-1:0] r_amt;
  logic [LOG2N-1:0] w_amt_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [LOG2N-1:0] w_amt;
  logic [WIDTH-1:0] w_stage [LOG2N];

  generate
    if (WIDTH == SHIFT_WIDTH) begin : g_pkg_amt
      assign w_amt = rot_left_amt(rot_code_t'(i_code));
    end else begin : g_gen_amt
      assign w_amt = i_code[CODEW-1] ? (LOG2N'(0) - i_code[LOG2N-1:0])
                                     : i_code[LOG2N-1:0];
    end
  endgenerate

  // Every stage is built; cnt picks which one lands in the data register,
  // so each word spends exactly LOG2N clocks in ROT regardless of amount.
  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_stage
      rot_stage #(
        .WIDTH (WIDTH),
        .SHIFT (1 << gi)
      ) u_rot_stage (
        .i_en   (r_amt[gi]),
        .i_data (r_data),
        .o_data (w_stage[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_amt_next   = r_amt;
    w_data_next  = r_data;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_data_next  = i_data;
          w_amt_next   = w_amt;
          w_cnt_next   = '0;
          w_state_next = ROT;
        end
      end
      ROT: begin
        w_data_next = w_stage[r_cnt];
        w_cnt_next  = r_cnt + LOG2N'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_amt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_amt   <= w_amt_next;
      r_data  <= w_data_next;
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_valid = (r_state == DONE);
  assign o_busy  = (r_state != IDLE);
  assign o_data  = r_data;

endmodule

// File: tb/tb_bit_unrotate_seq.sv
// Self-checking bench for bit_unrotate_seq: directed vector table, DONE
// back-pressure, mid-ROT reset, and a gather/unrotate sweep over all codes.
module tb_bit_unrotate_seq;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic [4:0]  i_code;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;

  bit_unrotate_seq #(.WIDTH(16)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_code  (i_code),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] y;
    logic [4:0]  code;
    logic [15:0] x;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Gather x with code {dir,k}: y[j] = x[(j+s) mod 16].
  function automatic logic [15:0] gather(input logic [15:0] x, input logic [4:0] code);
    logic [15:0] y;
    int s;
    int k;
    k = int'(code[3:0]);
    s = code[4] ? ((16 - k) % 16) : k;
    for (int j = 0; j < 16; j++) y[j] = x[(j + s) % 16];
    return y;
  endfunction

  // Accept one word, wait (bounded) for o_valid, take the result.
  task automatic send(input logic [15:0] y, input logic [4:0] c, input logic take,
                      output logic [15:0] got, output int lat);
    i_data  = y;
    i_code  = c;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    got = o_data;
    if (take) begin
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] held;
    logic [15:0] x;
    logic [15:0] y;
    int          lat;
    int          cyc;
    logic        any_valid;

    vecs[0] = '{16'h0001, 5'b00001, 16'h0002};
    vecs[1] = '{16'h0001, 5'b10001, 16'h8000};
    vecs[2] = '{16'h00F0, 5'b10100, 16'h000F};
    vecs[3] = '{16'hA5C3, 5'b00000, 16'hA5C3};
    vecs[4] = '{16'hA5C3, 5'b10000, 16'hA5C3};
    vecs[5] = '{16'h1234, 5'b01000, 16'h3412};
    vecs[6] = '{16'h8001, 5'b00011, 16'h000C};
    vecs[7] = '{16'hF00F, 5'b11111, 16'hE01F};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    i_code  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_busy",  32'(o_busy),  32'd0);
    chk("reset_data",  32'(o_data),  32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'd1);
      send(vecs[i].y, vecs[i].code, 1'b1, got, lat);
      $display("vec%0d y=%h code=%b -> x=%h lat=%0d", i, vecs[i].y, vecs[i].code, got, lat);
      chk($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].x));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_drop", i), 32'(o_valid), 32'd0);
    end

    // Back-pressure in DONE, with stray i_valid pulses that must be ignored.
    send(16'h0F00, 5'b00010, 1'b0, held, lat);
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data  = 16'hFFFF;
      i_code  = 5'b00111;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      chk($sformatf("bp_valid%0d", i), 32'(o_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), 32'(o_data), 32'h3C00);
      chk($sformatf("bp_ready%0d", i), 32'(o_ready), 32'd0);
    end
    $display("backpressure held x=%h", o_data);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("bp_release_valid", 32'(o_valid), 32'd0);
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    chk("bp_no_queue", 32'(o_busy), 32'd0);

    // Reset on the second ROT clock drops the in-flight word.
    i_data  = 16'h00FF;
    i_code  = 5'b00101;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    any_valid = 1'b0;
    for (cyc = 0; cyc < 6; cyc++) begin
      @(posedge i_clk); #1;
      if (o_valid) any_valid = 1'b1;
    end
    chk("rst_dropped", 32'(any_valid), 32'd0);
    send(16'h00FF, 5'b00101, 1'b1, got, lat);
    $display("after reset y=00ff code=00101 -> x=%h lat=%0d", got, lat);
    chk("rst_next_data", 32'(got), 32'h1FE0);
    chk("rst_next_lat",  32'(lat), 32'd4);

    // Sweep: gather random x with every code, expect x back.
    for (int c = 0; c < 32; c++) begin
      for (int w = 0; w < 20; w++) begin
        x = 16'($urandom);
        y = gather(x, 5'(c));
        send(y, 5'(c), 1'b1, got, lat);
        if (w == 0) $display("sweep code=%b x=%h y=%h -> %h lat=%0d", 5'(c), x, y, got, lat);
        chk($sformatf("sweep_c%0d_w%0d", c, w), {got, 16'(lat)}, {x, 16'd4});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
